// File: rtl/d8m_writer_pkg.sv
// Shared types and constants for the D8M frame writer: FSM states and the
// address/pixel field geometry.
package d8m_writer_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_e;

  localparam int ADDR_W   = 23;
  localparam int PIX_W    = 12;
  localparam int BYTE_MSB = 11;
  localparam int BYTE_LSB = 4;
  localparam int BYTE_W   = BYTE_MSB - BYTE_LSB + 1;

endpackage

// File: rtl/d8m_pix_pack.sv
// Pairs accepted 8-bit pixels into 16-bit words {odd, even}; word_ready is
// combinational on the accept cycle of the odd pixel.
module d8m_pix_pack
  import d8m_writer_pkg::*;
(
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                accept,
  input  logic                clear,
  input  logic [BYTE_W-1:0]   pix_byte,
  output logic                word_ready,
  output logic [2*BYTE_W-1:0] word
);

  logic              phase_q, phase_d;
  logic [BYTE_W-1:0] low_q, low_d;
  logic              phase_eff;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      phase_q <= 1'b0;
      low_q   <= '0;
    end else begin
      phase_q <= phase_d;
      low_q   <= low_d;
    end
  end

  // A clear on the same cycle as an accept makes that pixel the even one.
  always_comb begin
    phase_eff  = phase_q & ~clear;
    word_ready = accept & phase_eff;
    word       = {pix_byte, low_q};
    phase_d    = phase_eff;
    low_d      = low_q;
    if (accept) begin
      phase_d = ~phase_eff;
      if (!phase_eff) low_d = pix_byte;
    end
  end

endmodule

// File: rtl/d8m_frame_writer.sv
// Crops a window from the D8M pixel stream, packs pixel pairs and issues
// addressed writes to the frame-buffer FIFO under arm/done control.
module d8m_frame_writer
  import d8m_writer_pkg::*;
#(
  parameter int              X_START    = 0,
  parameter int              WIDTH      = 640,
  parameter int              Y_START    = 0,
  parameter int              HEIGHT     = 480,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 23'h000000,
  parameter bit              CONTINUOUS = 1'b0
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [PIX_W-1:0]  iDATA,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic [15:0]       iX_WR_CNT,
  input  logic [15:0]       iY_CONT,
  input  logic              iSTART,
  input  logic              iFIFO_FULL,
  output logic [15:0]       oWR_DATA,
  output logic              oWR_EN,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic              oBUSY,
  output logic              oFRAME_DONE,
  output logic              oOVERFLOW
);

  localparam logic [16:0] X_LO = 17'(X_START);
  localparam logic [16:0] X_HI = 17'(X_START + WIDTH);
  localparam logic [16:0] Y_LO = 17'(Y_START);
  localparam logic [16:0] Y_HI = 17'(Y_START + HEIGHT);

  state_e            state_q, state_d;
  logic              pre_fval_q, pre_lval_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic        fval_rise, fval_fall, lval_rise;
  logic        in_x, in_y, accept, start_cap, word_ready;
  logic [15:0] word;
  logic        data_unused;

  assign data_unused = ^iDATA[BYTE_LSB-1:0];

  assign fval_rise = ~pre_fval_q & iFVAL;
  assign fval_fall = pre_fval_q & ~iFVAL;
  assign lval_rise = ~pre_lval_q & iLVAL;

  // 17-bit compares so a window touching 16'hFFFF cannot wrap.
  assign in_x = ({1'b0, iX_WR_CNT} >= X_LO) && ({1'b0, iX_WR_CNT} < X_HI);
  assign in_y = ({1'b0, iY_CONT} >= Y_LO) && ({1'b0, iY_CONT} < Y_HI);

  assign accept    = (state_q == CAPTURE) & iFVAL & iLVAL & in_x & in_y;
  assign start_cap = (state_q == ARMED) & fval_rise;

  d8m_pix_pack u_pack (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .accept     (accept),
    .clear      (lval_rise | start_cap),
    .pix_byte   (iDATA[BYTE_MSB:BYTE_LSB]),
    .word_ready (word_ready),
    .word       (word)
  );

  // Edge detectors reload from the live inputs so a frame in flight at
  // reset release is not mistaken for a new frame start.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q    <= IDLE;
      pre_fval_q <= iFVAL;
      pre_lval_q <= iLVAL;
      addr_q     <= BASE_ADDR;
      wr_addr_q  <= BASE_ADDR;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_fval_q <= iFVAL;
      pre_lval_q <= iLVAL;
      addr_q     <= addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (iSTART) begin
          state_d = ARMED;
          ovf_d   = 1'b0;
        end
      end
      ARMED: begin
        if (fval_rise) begin
          state_d = CAPTURE;
          addr_d  = BASE_ADDR;
        end
      end
      CAPTURE: begin
        // Dropped words still consume an address to keep frame geometry.
        if (word_ready) begin
          addr_d = addr_q + 1'b1;
          if (iFIFO_FULL) begin
            ovf_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = word;
            wr_addr_d = addr_q;
          end
        end
        if (fval_fall) begin
          done_d  = 1'b1;
          state_d = CONTINUOUS ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign oWR_DATA    = wr_data_q;
  assign oWR_EN      = wr_en_q;
  assign oWR_ADDR    = wr_addr_q;
  assign oBUSY       = busy_q;
  assign oFRAME_DONE = done_q;
  assign oOVERFLOW   = ovf_q;

endmodule

// File: tb/tb_d8m_frame_writer.sv
// Directed bench for d8m_frame_writer: table of frame scenarios plus
// hand-written arm, reset and continuous-mode sequences.
module tb_d8m_frame_writer;

  localparam int X0 = 2, W = 4, Y0 = 1, H = 2;
  localparam logic [22:0] BASE = 23'h100;

  logic        clk = 1'b0;
  logic        rst_n, rst_c_n;
  logic [11:0] data;
  logic        fval, lval, start, full;
  logic [15:0] x, y;

  logic [15:0] wr_data, wr_data_c;
  logic        wr_en, wr_en_c;
  logic [22:0] wr_addr, wr_addr_c;
  logic        busy, busy_c, done, done_c, ovf, ovf_c;

  always #5 clk = ~clk;

  d8m_frame_writer #(.X_START(X0), .WIDTH(W), .Y_START(Y0), .HEIGHT(H),
                     .BASE_ADDR(BASE), .CONTINUOUS(1'b0)) dut (
    .iCLK(clk), .iRST(rst_n), .iDATA(data), .iFVAL(fval), .iLVAL(lval),
    .iX_WR_CNT(x), .iY_CONT(y), .iSTART(start), .iFIFO_FULL(full),
    .oWR_DATA(wr_data), .oWR_EN(wr_en), .oWR_ADDR(wr_addr), .oBUSY(busy),
    .oFRAME_DONE(done), .oOVERFLOW(ovf)
  );

  d8m_frame_writer #(.X_START(X0), .WIDTH(W), .Y_START(Y0), .HEIGHT(H),
                     .BASE_ADDR(BASE), .CONTINUOUS(1'b1)) dut_c (
    .iCLK(clk), .iRST(rst_c_n), .iDATA(data), .iFVAL(fval), .iLVAL(lval),
    .iX_WR_CNT(x), .iY_CONT(y), .iSTART(start), .iFIFO_FULL(full),
    .oWR_DATA(wr_data_c), .oWR_EN(wr_en_c), .oWR_ADDR(wr_addr_c), .oBUSY(busy_c),
    .oFRAME_DONE(done_c), .oOVERFLOW(ovf_c)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [22:0] wa_q[$];
  logic [15:0] wd_q[$];
  logic [22:0] wa_c[$];
  logic [15:0] wd_c[$];
  int done_cnt = 0, done_cyc = 0, done_c_cnt = 0, busy_c_drop = 0;
  logic c_armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      $display("[TB] write addr=%06h data=%04h", wr_addr, wr_data);
    end
    if (wr_en_c) begin
      wa_c.push_back(wr_addr_c);
      wd_c.push_back(wr_data_c);
      $display("[TB] cont write addr=%06h data=%04h", wr_addr_c, wr_data_c);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (done_c) done_c_cnt++;
    if (c_armed && !busy_c) busy_c_drop++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Four lines of 8 pixels (or 3 on short_row), data[11:4] = column index.
  // iFIFO_FULL is raised on the odd-pixel cycle of captured word full_word.
  task automatic send_frame(input int full_word, input int short_row,
                            input bit start_at_rise, output int fall_cyc);
    int words;
    int len;
    words = 0;
    fval = 1'b1;
    if (start_at_rise) start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    for (int l = 0; l < 4; l++) begin
      len = (l == short_row) ? 3 : 8;
      for (int p = 0; p < len; p++) begin
        lval = 1'b1;
        x    = p[15:0];
        y    = l[15:0];
        data = {p[7:0], 4'h0};
        full = 1'b0;
        if (p >= X0 && p < X0 + W && l >= Y0 && l < Y0 + H && ((p - X0) % 2 == 1)) begin
          if (words == full_word) full = 1'b1;
          words++;
        end
        tick(1);
      end
      lval = 1'b0;
      full = 1'b0;
      x    = '0;
      tick(2);
    end
    fval = 1'b0;
    fall_cyc = cyc;
    tick(3);
  endtask

  typedef struct {
    string            name;
    int               full_word;
    int               short_row;
    int               exp_n;
    logic [3:0][22:0] addr;
    logic [3:0][15:0] wdat;
    logic             exp_ovf;
  } scen_t;

  scen_t tbl[3];

  initial begin
    int fc, n0, d0, c0;

    tbl[0] = '{"basic", -1, -1, 4,
               {23'h103, 23'h102, 23'h101, 23'h100},
               {16'h0504, 16'h0302, 16'h0504, 16'h0302}, 1'b0};
    tbl[1] = '{"fifo_full", 1, -1, 3,
               {23'h000, 23'h103, 23'h102, 23'h100},
               {16'h0000, 16'h0504, 16'h0302, 16'h0302}, 1'b1};
    tbl[2] = '{"odd_line", -1, 1, 2,
               {23'h000, 23'h000, 23'h101, 23'h100},
               {16'h0000, 16'h0000, 16'h0504, 16'h0302}, 1'b0};

    rst_n = 1'b0; rst_c_n = 1'b0;
    data = '0; fval = 1'b0; lval = 1'b0; x = '0; y = '0; start = 1'b0; full = 1'b0;
    tick(3);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_addr", wr_addr, BASE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 3; i++) begin
      n0 = wa_q.size();
      d0 = done_cnt;
      pulse_start();
      check({tbl[i].name, "_ovf_cleared"}, ovf, 0);
      tick(1);
      check({tbl[i].name, "_armed_busy"}, busy, 1);
      send_frame(tbl[i].full_word, tbl[i].short_row, 1'b0, fc);
      check({tbl[i].name, "_count"}, wa_q.size() - n0, tbl[i].exp_n);
      for (int k = 0; k < tbl[i].exp_n; k++) begin
        if (n0 + k < wa_q.size()) begin
          check({tbl[i].name, "_addr"}, wa_q[n0 + k], tbl[i].addr[k]);
          check({tbl[i].name, "_data"}, wd_q[n0 + k], tbl[i].wdat[k]);
        end
      end
      check({tbl[i].name, "_done_cnt"}, done_cnt - d0, 1);
      check({tbl[i].name, "_done_time"}, done_cyc, fc + 1);
      check({tbl[i].name, "_ovf"}, ovf, tbl[i].exp_ovf);
      check({tbl[i].name, "_idle"}, busy, 0);
      $display("[TB] scenario %s done", tbl[i].name);
    end

    // Arm while a frame is in flight: that frame must be skipped.
    n0 = wa_q.size();
    d0 = done_cnt;
    fval = 1'b1;
    tick(3);
    pulse_start();
    tick(2);
    check("midarm_busy", busy, 1);
    fval = 1'b0;
    tick(3);
    check("midarm_no_writes", wa_q.size() - n0, 0);
    check("midarm_no_done", done_cnt - d0, 0);
    send_frame(-1, -1, 1'b0, fc);
    check("midarm_count", wa_q.size() - n0, 4);
    if (wa_q.size() - n0 == 4) begin
      check("midarm_first_addr", wa_q[n0], BASE);
      check("midarm_last_addr", wa_q[n0 + 3], BASE + 23'd3);
    end
    $display("[TB] mid-frame arm sequence done");

    // iSTART coincident with the frame start: only arm.
    n0 = wa_q.size();
    send_frame(-1, -1, 1'b1, fc);
    check("simul_no_writes", wa_q.size() - n0, 0);
    check("simul_armed", busy, 1);
    send_frame(-1, -1, 1'b0, fc);
    check("simul_next_count", wa_q.size() - n0, 4);
    $display("[TB] simultaneous start sequence done");

    // Reset in the middle of a captured line, right as a word is output.
    n0 = wa_q.size();
    d0 = done_cnt;
    pulse_start();
    fval = 1'b1;
    tick(2);
    for (int p = 0; p < 4; p++) begin
      lval = 1'b1; x = p[15:0]; y = 16'd1; data = {p[7:0], 4'h0};
      tick(1);
    end
    check("prerst_wr_en", wr_en, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_wr_addr", wr_addr, BASE);
    check("midrst_busy", busy, 0);
    tick(1);
    rst_n = 1'b1;
    for (int p = 4; p < 8; p++) begin
      x = p[15:0]; data = {p[7:0], 4'h0};
      tick(1);
    end
    lval = 1'b0;
    tick(2);
    fval = 1'b0;
    tick(3);
    send_frame(-1, -1, 1'b0, fc);
    check("postrst_no_writes", wa_q.size() - n0, 0);
    check("postrst_no_done", done_cnt - d0, 0);
    check("postrst_idle", busy, 0);
    pulse_start();
    send_frame(-1, -1, 1'b0, fc);
    check("postrst_count", wa_q.size() - n0, 4);
    if (wa_q.size() - n0 == 4) check("postrst_first_addr", wa_q[n0], BASE);
    $display("[TB] reset mid-capture sequence done");

    // Continuous mode: three back-to-back frames after a single arm.
    rst_c_n = 1'b1;
    tick(2);
    c0 = done_c_cnt;
    pulse_start();
    tick(1);
    c_armed = 1'b1;
    for (int f = 0; f < 3; f++) begin
      n0 = wa_c.size();
      send_frame(-1, -1, 1'b0, fc);
      check("cont_count", wa_c.size() - n0, 4);
      if (wa_c.size() - n0 == 4) begin
        check("cont_first_addr", wa_c[n0], BASE);
        check("cont_first_data", wd_c[n0], 16'h0302);
        check("cont_last_addr", wa_c[n0 + 3], BASE + 23'd3);
      end
      $display("[TB] continuous frame %0d done", f);
    end
    c_armed = 1'b0;
    check("cont_done_pulses", done_c_cnt - c0, 3);
    check("cont_busy_held", busy_c_drop, 0);
    check("cont_still_busy", busy_c, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
